spi_frame_shifter: RTL and testbench
====================================

# spi_frame_shifter

Data-path stage downstream of the SPI master FSM: consumes its `CS`/`SCLK` (SPI mode 0, MSB first) and performs the per-frame shifting. It drives MOSI from a one-deep transmit holding register, assembles MISO bits into received frames, tracks the frame index within a burst, and flags underrun, overrun and framing errors. The block runs entirely in the `clk` domain and detects SCLK/CS edges by sampling.

## Interface
- `F_SIZE`, 8, bits per frame (≥2)
- `F_NUM`, 1, frames per burst; `frame_idx_o` wraps at this value
- `C_SIZE`, $clog2(F_SIZE)+1, bit counter width
- `FC_SIZE`, $clog2(F_NUM)+1, frame index width

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `cs_i`  in  1  chip select from master FSM, active-low, synchronous to `clk`
- `sclk_i`  in  1  SPI clock from master FSM, synchronous to `clk`; each high and low phase ≥2 `clk`
- `miso_i`  in  1  serial input from slave
- `tx_data_i`  in  F_SIZE  next frame to transmit
- `tx_valid_i`  in  1  `tx_data_i` valid
- `tx_ready_o`  out  1  holding register empty, `!hold_full`
- `mosi_o`  out  1  serial output
- `rx_data_o`  out  F_SIZE  last received frame
- `rx_valid_o`  out  1  `rx_data_o` unread; held until `rx_ready_i`
- `rx_ready_i`  in  1  consumer takes `rx_data_o`
- `frame_idx_o`  out  FC_SIZE  completed frames mod F_NUM
- `clr_i`  in  1  synchronous clear of sticky flags
- `underrun_o`  out  1  sticky: frame started with empty holding register
- `overrun_o`  out  1  sticky: frame completed while `rx_valid_o` was high and `rx_ready_i` was low
- `frame_err_o`  out  1  sticky: CS rose mid-frame, or SCLK rose after bit F_SIZE

## Operation
- Registers `cs_q` and `sclk_q` hold the previous-cycle `cs_i` and `sclk_i`. Edge terms: `cs_fall = cs_q & ~cs_i`, `cs_rise = ~cs_q & cs_i`, `sck_rise = sclk_i & ~sclk_q`, `sck_fall = ~sclk_i & sclk_q`.
- FSM states are SYNC, IDLE and ACTIVE. Reset enters SYNC.
  - SYNC → IDLE when `cs_i`=1. All SCLK edges are ignored in SYNC, so a frame in progress at reset release is dropped silently.
  - IDLE → ACTIVE on `cs_fall`.
  - ACTIVE → IDLE on `cs_rise`.
- On `cs_fall` in IDLE:
  - `bit_cnt` is cleared to 0.
  - If `hold_full`: `tx_sr` ← `tx_hold` and `hold_full` is cleared.
  - Otherwise: `tx_sr` ← all ones and `underrun_o` is set.
- TX holding register: data is accepted when `tx_valid_i & tx_ready_o`. An accept in the same cycle as an underrun `cs_fall` fills the register for the next frame only.
- `mosi_o` is `tx_sr[F_SIZE-1]` in ACTIVE and 0 otherwise.
- On `sck_fall` in ACTIVE: `tx_sr` shifts left and fills with 0.
- On `sck_rise` in ACTIVE with `bit_cnt`<F_SIZE:
  - `rx_sr` ← {`rx_sr`[F_SIZE-2:0], `miso_i`}.
  - `bit_cnt` increments.
  - When `bit_cnt`+1==F_SIZE: `rx_data_o` ← the shifted value and `rx_valid_o` ← 1. `overrun_o` is set if `rx_valid_o`&`~rx_ready_i` in that cycle. `frame_idx_o` increments, wrapping from F_NUM-1 to 0.
- On `sck_rise` in ACTIVE with `bit_cnt`==F_SIZE: `frame_err_o` is set and the edge is ignored.
- On `cs_rise` with 0<`bit_cnt`<F_SIZE: `frame_err_o` is set and the partial frame is discarded. `frame_idx_o` is unchanged.
- `rx_valid_o` clears on `rx_ready_i`. If a frame completes in that same cycle, `rx_valid_o` stays 1 with the new data and no overrun is flagged.
- `clr_i` clears the three sticky flags. A flag set event in the same cycle as `clr_i` takes priority.

## Timing
- Reset values:
  - Outputs: `mosi_o`=0, `rx_data_o`=0, `rx_valid_o`=0, `tx_ready_o`=1, `frame_idx_o`=0, all flags 0.
  - Internal: `cs_q`=1, `sclk_q`=0, `hold_full`=0.
- `mosi_o` shows the frame MSB 1 `clk` after `cs_i` falls. It updates 1 `clk` after each `sclk_i` fall.
- MISO is sampled at the first `clk` edge where `sclk_i`=1 and `sclk_q`=0.
- `rx_valid_o` and `rx_data_o` are registered at that same edge for the final bit, so they are visible 1 `clk` after `sclk_i` rises.
- `tx_ready_o` is combinational from `hold_full`. It returns to 1 the cycle after the load on `cs_fall`.
- Asserting `rst_n` mid-frame drops all state immediately, with no partial output.

## Test plan
- Mode-0 loopback, `mosi_o`→`miso_i`, F_NUM=1: preload 0xA5, then run one 8-SCLK frame → MOSI bits 1,0,1,0,0,1,0,1; `rx_data_o`=0xA5; `rx_valid_o`=1; `frame_idx_o`=0; no flags set.
- F_NUM=3 burst with 0x01,0x02,0x03 fed just-in-time, CS pulsing high 1 `clk` between frames → three `rx_valid_o` events; `frame_idx_o` goes 1,2,0; `underrun_o`=0.
- Empty holding register at `cs_fall` → MOSI 0xFF, `underrun_o`=1. Then `clr_i` → `underrun_o`=0.
- Keep `rx_ready_i`=0 over two frames → `overrun_o`=1 and `rx_data_o` holds the second frame. Repeat with `rx_ready_i` pulsed on the completion cycle → `overrun_o` stays 0.
- CS raised after 5 SCLKs → `frame_err_o`=1, no `rx_valid_o`, `frame_idx_o` unchanged. Also a 9th SCLK in a frame → `frame_err_o`=1 and `rx_data_o` unchanged.
- Assert `rst_n` after bit 3 with CS held low, then release → no frame completes until CS goes high and falls again. The next full frame is received correctly.

Source files
------------

// File: rtl/spi_frame_shifter.sv
// spi_frame_shifter: per-frame data path that sits behind an SPI mode-0 master FSM.
// It samples CS/SCLK in the clk domain, shifts MOSI out of a one-deep transmit
// holding register, assembles MISO into frames, counts frames within a burst,
// and keeps sticky underrun / overrun / framing error flags.
//
// Handshakes:
//   tx: a word moves into the holding register on a clk edge where
//       tx_valid_i && tx_ready_o; tx_ready_o is simply "holding register empty".
//   rx: rx_valid_o rises with a new frame and stays high until a clk edge with
//       rx_ready_i high; a frame completing on that same edge keeps it high.
module spi_frame_shifter #(
  parameter int F_SIZE  = 8,
  parameter int F_NUM   = 1,
  parameter int C_SIZE  = $clog2(F_SIZE) + 1,
  parameter int FC_SIZE = $clog2(F_NUM) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cs_i,
  input  logic               sclk_i,
  input  logic               miso_i,
  input  logic [F_SIZE-1:0]  tx_data_i,
  input  logic               tx_valid_i,
  output logic               tx_ready_o,
  output logic               mosi_o,
  output logic [F_SIZE-1:0]  rx_data_o,
  output logic               rx_valid_o,
  input  logic               rx_ready_i,
  output logic [FC_SIZE-1:0] frame_idx_o,
  input  logic               clr_i,
  output logic               underrun_o,
  output logic               overrun_o,
  output logic               frame_err_o
);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Previous-cycle copies of the master's CS and SCLK for edge detection.
  logic cs_q, sclk_q;

  logic [F_SIZE-1:0]  hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [F_SIZE-1:0]  tx_sr_q, tx_sr_d;
  logic [F_SIZE-1:0]  rx_sr_q, rx_sr_d;
  logic [C_SIZE-1:0]  bit_cnt_q, bit_cnt_d;
  logic [F_SIZE-1:0]  rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic [FC_SIZE-1:0] frame_idx_q, frame_idx_d;
  logic               underrun_q, underrun_d;
  logic               overrun_q, overrun_d;
  logic               frame_err_q, frame_err_d;

  logic cs_fall, cs_rise, sck_rise, sck_fall;
  logic in_active, frame_start, tx_accept;
  logic underrun_set, overrun_set, frame_err_set;
  logic [F_SIZE-1:0] rx_shift;

  assign cs_fall  = cs_q & ~cs_i;
  assign cs_rise  = ~cs_q & cs_i;
  assign sck_rise = sclk_i & ~sclk_q;
  assign sck_fall = ~sclk_i & sclk_q;

  assign in_active   = (state_q == ST_ACTIVE);
  assign frame_start = (state_q == ST_IDLE) & cs_fall;
  assign tx_accept   = tx_valid_i & ~hold_full_q;

  // State register: reset lands in SYNC so a frame already running is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: wait for CS idle, then follow CS falling/rising edges.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC:   if (cs_i)    state_d = ST_IDLE;
      ST_IDLE:   if (cs_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (cs_rise) state_d = ST_IDLE;
      default:   state_d = ST_SYNC;
    endcase
  end

  // Data path next-state: holding register, shifters, frame completion, flags.
  always_comb begin
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    tx_sr_d       = tx_sr_q;
    rx_sr_d       = rx_sr_q;
    bit_cnt_d     = bit_cnt_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    frame_idx_d   = frame_idx_q;
    underrun_set  = 1'b0;
    overrun_set   = 1'b0;
    frame_err_set = 1'b0;
    rx_shift      = {rx_sr_q[F_SIZE-2:0], miso_i};

    // Accept only into an empty register, so it never collides with a load.
    if (tx_accept) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end

    // Frame start: move the held word into the shifter, or send all ones.
    if (frame_start) begin
      bit_cnt_d = '0;
      if (hold_full_q) begin
        tx_sr_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_sr_d      = '1;
        underrun_set = 1'b1;
      end
    end

    if (rx_ready_i) begin
      rx_valid_d = 1'b0;
    end

    if (in_active) begin
      if (cs_rise) begin
        // A partial frame is dropped; its bits never reach rx_data_o.
        if ((bit_cnt_q != '0) && (bit_cnt_q < C_SIZE'(F_SIZE))) begin
          frame_err_set = 1'b1;
        end
      end else begin
        if (sck_fall) begin
          tx_sr_d = {tx_sr_q[F_SIZE-2:0], 1'b0};
        end
        if (sck_rise) begin
          if (bit_cnt_q < C_SIZE'(F_SIZE)) begin
            rx_sr_d   = rx_shift;
            bit_cnt_d = bit_cnt_q + C_SIZE'(1);
            if (bit_cnt_q == C_SIZE'(F_SIZE - 1)) begin
              rx_data_d   = rx_shift;
              rx_valid_d  = 1'b1;
              overrun_set = rx_valid_q & ~rx_ready_i;
              if (frame_idx_q == FC_SIZE'(F_NUM - 1)) begin
                frame_idx_d = '0;
              end else begin
                frame_idx_d = frame_idx_q + FC_SIZE'(1);
              end
            end
          end else begin
            // Extra SCLK beyond a full frame: flag it and leave data alone.
            frame_err_set = 1'b1;
          end
        end
      end
    end

    // Sticky flags: a new event outranks a simultaneous clear.
    underrun_d  = (underrun_q  & ~clr_i) | underrun_set;
    overrun_d   = (overrun_q   & ~clr_i) | overrun_set;
    frame_err_d = (frame_err_q & ~clr_i) | frame_err_set;
  end

  // Data path registers; reset drops any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q        <= 1'b1;
      sclk_q      <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      bit_cnt_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_idx_q <= '0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cs_q        <= cs_i;
      sclk_q      <= sclk_i;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_idx_q <= frame_idx_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign mosi_o      = in_active & tx_sr_q[F_SIZE-1];
  assign tx_ready_o  = ~hold_full_q;
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_idx_o = frame_idx_q;
  assign underrun_o  = underrun_q;
  assign overrun_o   = overrun_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_spi_frame_shifter.sv
// Bench for spi_frame_shifter: MOSI looped back to MISO, directed frames, a
// scoreboard of expected received frames popped by a monitor on each frame
// index step, and direct checks of flags, reset values and MOSI bits.
module tb_spi_frame_shifter;

  localparam int W = 11;  // {frame_idx[2:0], data[7:0]}

  logic       clk;
  logic       rst_n;
  logic       cs;
  logic       sclk;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       rx_ready;
  logic       clr;

  logic       tx_ready, mosi, rx_valid, underrun, overrun, frame_err;
  logic [7:0] rx_data;
  logic [2:0] frame_idx;

  logic       tx_ready1, mosi1, rx_valid1, underrun1, overrun1, frame_err1;
  logic [7:0] rx_data1;
  logic [0:0] frame_idx1;

  int checks;
  int errors;

  logic [W-1:0] exp_q[$];
  logic [2:0]   model_idx;
  logic [2:0]   last_idx;

  assign miso = mosi;

  spi_frame_shifter #(.F_SIZE(8), .F_NUM(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .cs_i(cs), .sclk_i(sclk), .miso_i(miso),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .mosi_o(mosi), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .rx_ready_i(rx_ready), .frame_idx_o(frame_idx), .clr_i(clr),
    .underrun_o(underrun), .overrun_o(overrun), .frame_err_o(frame_err)
  );

  spi_frame_shifter #(.F_SIZE(8), .F_NUM(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cs_i(cs), .sclk_i(sclk), .miso_i(miso),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready1),
    .mosi_o(mosi1), .rx_data_o(rx_data1), .rx_valid_o(rx_valid1),
    .rx_ready_i(rx_ready), .frame_idx_o(frame_idx1), .clr_i(clr),
    .underrun_o(underrun1), .overrun_o(overrun1), .frame_err_o(frame_err1)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Driver: load the holding register once it is free.
  task automatic push_tx(input logic [7:0] d);
    int n;
    n = 0;
    while (!tx_ready && n < 50) begin
      tick();
      n++;
    end
    if (!tx_ready) begin
      checks++;
      errors++;
      $display("FAIL tx_ready_timeout actual=0 expected=1");
    end
    tx_valid = 1'b1;
    tx_data  = d;
    tick();
    tx_valid = 1'b0;
  endtask

  // Driver: one CS-low window with nbits SCLK pulses (2 clk high, 2 clk low).
  task automatic run_frame(input int nbits, input logic [7:0] exp_data,
                           input bit pulse_last, input bit have_next,
                           input logic [7:0] next_data, input int gap);
    logic saved_ready;
    cs = 1'b0;
    tick();
    chk("mosi_msb", mosi, exp_data[7]);
    chk("tx_ready_after_load", tx_ready, 1);
    if (have_next) push_tx(next_data);
    else tick();
    if (nbits >= 8) begin
      model_idx = (model_idx == 3'd2) ? 3'd0 : model_idx + 3'd1;
      exp_q.push_back({model_idx, exp_data});
    end
    for (int i = 0; i < nbits; i++) begin
      if (i < 8) chk("mosi_bit", mosi, exp_data[7-i]);
      saved_ready = rx_ready;
      sclk = 1'b1;
      if (pulse_last && i == 7) rx_ready = 1'b1;
      tick();
      rx_ready = saved_ready;
      tick();
      sclk = 1'b0;
      tick();
      tick();
    end
    cs = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic clear_flags();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mosi"}, mosi, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_tx_ready"}, tx_ready, 1);
    chk({tag, "_frame_idx"}, frame_idx, 0);
    chk({tag, "_flags"}, {underrun, overrun, frame_err}, 0);
  endtask

  // Monitor: each frame index step is a completed frame; compare to scoreboard.
  initial last_idx = '0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      last_idx = frame_idx;
    end else if (frame_idx != last_idx) begin
      last_idx = frame_idx;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame actual=%0h expected=none", rx_data);
      end else begin
        e = exp_q.pop_front();
        chk("rx_data", rx_data, e[7:0]);
        chk("rx_frame_idx", frame_idx, e[10:8]);
        chk("rx_valid", rx_valid, 1);
        chk("rx_data_fnum1", rx_data1, e[7:0]);
        chk("frame_idx_fnum1", frame_idx1, 0);
      end
    end
  end

  // Stimulus
  initial begin
    checks    = 0;
    errors    = 0;
    model_idx = '0;
    rst_n     = 1'b0;
    cs        = 1'b1;
    sclk      = 1'b0;
    tx_data   = '0;
    tx_valid  = 1'b0;
    rx_ready  = 1'b1;
    clr       = 1'b0;
    #3;
    check_reset_values("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Burst of three frames, next word loaded just after each CS fall.
    push_tx(8'h01);
    run_frame(8, 8'h01, 0, 1, 8'h02, 1);
    run_frame(8, 8'h02, 0, 1, 8'h03, 1);
    run_frame(8, 8'h03, 0, 0, 8'h00, 2);
    chk("burst_underrun", underrun, 0);
    chk("burst_idx_wrap", frame_idx, 0);

    // Loopback of 0xA5.
    push_tx(8'hA5);
    chk("tx_ready_full", tx_ready, 0);
    run_frame(8, 8'hA5, 0, 0, 8'h00, 2);
    chk("a5_flags", {underrun, overrun, frame_err}, 0);
    chk("a5_mosi_idle", mosi, 0);

    // Underrun: nothing held at CS fall, all ones go out.
    run_frame(8, 8'hFF, 0, 0, 8'h00, 2);
    chk("underrun_set", underrun, 1);
    clear_flags();
    chk("underrun_clr", underrun, 0);

    // Overrun: two frames with no consumer.
    rx_ready = 1'b0;
    push_tx(8'h11);
    run_frame(8, 8'h11, 0, 0, 8'h00, 2);
    chk("overrun_first", overrun, 0);
    push_tx(8'h22);
    run_frame(8, 8'h22, 0, 0, 8'h00, 2);
    chk("overrun_set", overrun, 1);
    chk("overrun_data", rx_data, 8'h22);
    rx_ready = 1'b1;
    tick();
    chk("rx_valid_drained", rx_valid, 0);
    clear_flags();
    chk("overrun_clr", overrun, 0);

    // Consumer takes the old frame on the completion edge of the next.
    rx_ready = 1'b0;
    push_tx(8'h33);
    run_frame(8, 8'h33, 0, 0, 8'h00, 2);
    push_tx(8'h44);
    run_frame(8, 8'h44, 1, 0, 8'h00, 2);
    chk("pulse_no_overrun", overrun, 0);
    chk("pulse_valid_kept", rx_valid, 1);
    chk("pulse_data", rx_data, 8'h44);
    rx_ready = 1'b1;
    tick();

    // CS rises after five SCLKs.
    push_tx(8'h55);
    run_frame(5, 8'h55, 0, 0, 8'h00, 2);
    chk("short_frame_err", frame_err, 1);
    chk("short_no_valid", rx_valid, 0);
    chk("short_data_kept", rx_data, 8'h44);
    chk("short_idx_kept", frame_idx, model_idx);
    clear_flags();
    chk("frame_err_clr", frame_err, 0);

    // Ninth SCLK within one frame.
    push_tx(8'h66);
    run_frame(9, 8'h66, 0, 0, 8'h00, 2);
    chk("long_frame_err", frame_err, 1);
    chk("long_data_kept", rx_data, 8'h66);
    clear_flags();

    // Reset in the middle of a frame, CS still low on release.
    push_tx(8'h77);
    cs = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b1; tick(); tick();
      sclk = 1'b0; tick(); tick();
    end
    rst_n = 1'b0;
    model_idx = '0;
    #1;
    check_reset_values("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b1; tick(); tick();
      sclk = 1'b0; tick(); tick();
    end
    chk("sync_no_valid", rx_valid, 0);
    chk("sync_idx", frame_idx, 0);
    chk("sync_no_underrun", underrun, 0);
    cs = 1'b1;
    tick();
    tick();
    push_tx(8'h5A);
    run_frame(8, 8'h5A, 0, 0, 8'h00, 2);
    chk("post_reset_flags", {underrun, overrun, frame_err}, 0);

    repeat (4) tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
